shift_reg_univ: RTL and testbench

Parametrised universal register that generalises our single-bit D flip-flop into a WIDTH-bit register with eight operating modes: hold, shift, rotate, parallel load, synchronous clear and synchronous preset. It carries a saturating counter of shift/rotate operations performed since the last load, clear or preset. It is the general storage/shift primitive for serialisers, LFSR front-ends and datapath staging registers.

---
 rtl/shift_reg_univ_pkg.sv | 20 ++
 rtl/shift_reg_univ_if.sv | 31 +++
 rtl/shift_reg_defs.vh | 15 +
 rtl/shift_reg_univ_sat_counter.sv | 26 ++
 rtl/shift_reg_univ.sv | 62 ++++++
 tb/tb_shift_reg_univ.sv | 162 ++++++++++++++++
 6 files changed

// File: rtl/shift_reg_univ_pkg.sv
// Shared types and mode classification helpers for the universal shift register.
// The mode codes themselves live in shift_reg_defs.vh and are re-exported from here.
package shift_reg_univ_pkg;

  `include "shift_reg_defs.vh"

  typedef logic [2:0] mode_t;

  // Modes that advance the shift counter.
  function automatic logic mode_shifts(input mode_t m);
    return (m == MODE_SHR) || (m == MODE_SHL) ||
           (m == MODE_ROR) || (m == MODE_ROL);
  endfunction

  // Modes that restart the shift counter from zero.
  function automatic logic mode_restarts(input mode_t m);
    return (m == MODE_LOAD) || (m == MODE_CLEAR) || (m == MODE_PRESET);
  endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control, data and status bundle of the universal shift register.
// master drives operations into the register, slave is the register itself.
interface shift_reg_univ_if
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CNT_W-1:0] shift_cnt;
  logic             cnt_sat;

  modport master (
    output en, mode, d, sin_r, sin_l,
    input  q, sout_r, sout_l, shift_cnt, cnt_sat
  );

  modport slave (
    input  en, mode, d, sin_r, sin_l,
    output q, sout_r, sout_l, shift_cnt, cnt_sat
  );

endinterface

// File: rtl/shift_reg_defs.vh
// Mode code constants shared by the universal shift register, its package and the bench.
// Guarded so the file can be pulled in from more than one compilation unit.
`ifndef SHIFT_REG_DEFS_VH
`define SHIFT_REG_DEFS_VH

localparam logic [2:0] MODE_HOLD   = 3'b000;
localparam logic [2:0] MODE_SHR    = 3'b001;
localparam logic [2:0] MODE_SHL    = 3'b010;
localparam logic [2:0] MODE_LOAD   = 3'b011;
localparam logic [2:0] MODE_ROR    = 3'b100;
localparam logic [2:0] MODE_ROL    = 3'b101;
localparam logic [2:0] MODE_CLEAR  = 3'b110;
localparam logic [2:0] MODE_PRESET = 3'b111;

`endif

// File: rtl/shift_reg_univ_sat_counter.sv
// Saturating up-counter: sticks at all-ones until cleared, never wraps.
// clr wins over inc so a restart on the same edge as a shift always lands on zero.
module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  assign sat = &cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// WIDTH-bit universal register: hold, shift, rotate, load, clear and preset,
// plus a saturating count of shift/rotate operations since the last restart.
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 4
) (
  input logic             clk,
  input logic             reset_n,
  shift_reg_univ_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             cnt_inc;
  logic             cnt_clr;

  // Next-state mux; only consulted when en is high.
  always_comb begin
    q_next = q;
    case (bus.mode)
      MODE_HOLD:   q_next = q;
      MODE_SHR:    q_next = {bus.sin_r, q[WIDTH-1:1]};
      MODE_SHL:    q_next = {q[WIDTH-2:0], bus.sin_l};
      MODE_LOAD:   q_next = bus.d;
      MODE_ROR:    q_next = {q[0], q[WIDTH-1:1]};
      MODE_ROL:    q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_CLEAR:  q_next = '0;
      MODE_PRESET: q_next = RST_VAL;
      default:     q_next = q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RST_VAL;
    end else if (bus.en) begin
      q <= q_next;
    end
  end

  assign cnt_inc = bus.en && mode_shifts(bus.mode);
  assign cnt_clr = bus.en && mode_restarts(bus.mode);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .cnt     (bus.shift_cnt),
    .sat     (bus.cnt_sat)
  );

  assign bus.q      = q;
  assign bus.sout_r = q[0];
  assign bus.sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8, RST_VAL=8'hA5, CNT_W=4).
// Expected values are hand-computed from the mode definitions.
module tb_shift_reg_univ;
  import shift_reg_univ_pkg::*;

  localparam int         WIDTH   = 8;
  localparam int         CNT_W   = 4;
  localparam logic [7:0] RST_VAL = 8'hA5;

  logic clk;
  logic reset_n;
  int   check_count;
  int   pass_count;

  shift_reg_univ_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_reg_univ #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one operation, then sample 1 time unit after the active edge.
  task automatic apply_stimulus(input logic en, input mode_t mode, input logic [7:0] d,
                                input logic sin_r, input logic sin_l);
    bus.en    = en;
    bus.mode  = mode;
    bus.d     = d;
    bus.sin_r = sin_r;
    bus.sin_l = sin_l;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] q, input logic [3:0] cnt);
    check_output({tag, ".q"}, 32'(bus.q), 32'(q));
    check_output({tag, ".cnt"}, 32'(bus.shift_cnt), 32'(cnt));
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    reset_n     = 1'b0;
    bus.en      = 1'b0;
    bus.mode    = MODE_HOLD;
    bus.d       = '0;
    bus.sin_r   = 1'b0;
    bus.sin_l   = 1'b0;

    // Reset state, then release away from the clock edge.
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 8'hA5, 4'd0);
    check_output("reset.sat", 32'(bus.cnt_sat), 32'd0);
    #4 reset_n = 1'b1;

    // Build q=3C with a nonzero count, then reset mid-cycle.
    apply_stimulus(1'b1, MODE_LOAD, 8'h78, 1'b0, 1'b0);
    apply_stimulus(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0);
    check_state("pre_async", 8'h3C, 4'd1);
    #2 reset_n = 1'b0;
    #1;
    check_state("async_rst", 8'hA5, 4'd0);
    #2 reset_n = 1'b1;
    apply_stimulus(1'b1, MODE_HOLD, 8'hFF, 1'b1, 1'b1);
    check_state("hold1", 8'hA5, 4'd0);
    apply_stimulus(1'b1, MODE_HOLD, 8'h00, 1'b1, 1'b1);
    check_state("hold2", 8'hA5, 4'd0);

    // Shift right with sin_r=1 from 81.
    apply_stimulus(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
    check_state("load81", 8'h81, 4'd0);
    check_output("load81.sout_r", 32'(bus.sout_r), 32'd1);
    apply_stimulus(1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0);
    check_output("shr1.q", 32'(bus.q), 32'hC0);
    check_output("shr1.sout_r", 32'(bus.sout_r), 32'd0);
    apply_stimulus(1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0);
    check_output("shr2.q", 32'(bus.q), 32'hE0);
    apply_stimulus(1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0);
    check_state("shr3", 8'hF0, 4'd3);
    check_output("shr3.sout_l", 32'(bus.sout_l), 32'd1);

    // Rotates ignore the serial inputs.
    apply_stimulus(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
    apply_stimulus(1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0);
    check_state("rol", 8'h03, 4'd1);
    apply_stimulus(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0);
    check_output("ror1.q", 32'(bus.q), 32'h81);
    apply_stimulus(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b1);
    check_state("ror2", 8'hC0, 4'd3);

    // Eight rotations return to the original pattern.
    apply_stimulus(1'b1, MODE_LOAD, 8'h96, 1'b1, 1'b1);
    apply_stimulus(1'b1, MODE_ROR, 8'h00, 1'b1, 1'b1);
    check_output("ror96_1.q", 32'(bus.q), 32'h4B);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, MODE_ROR, 8'h00, 1'b1, 1'b1);
    check_state("ror96_8", 8'h96, 4'd8);

    // Twenty left shifts: q empties at edge 8, count saturates at edge 15.
    apply_stimulus(1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      apply_stimulus(1'b1, MODE_SHL, 8'hFF, 1'b1, 1'b0);
      if (e == 1) check_output("shl1.q", 32'(bus.q), 32'h02);
      if (e == 7) begin
        check_output("shl7.q", 32'(bus.q), 32'h80);
        check_output("shl7.sout_l", 32'(bus.sout_l), 32'd1);
      end
      if (e == 8) check_state("shl8", 8'h00, 4'd8);
      if (e == 14) check_output("shl14.sat", 32'(bus.cnt_sat), 32'd0);
      if (e == 15) begin
        check_state("shl15", 8'h00, 4'd15);
        check_output("shl15.sat", 32'(bus.cnt_sat), 32'd1);
      end
    end
    check_state("shl20", 8'h00, 4'd15);
    check_output("shl20.sat", 32'(bus.cnt_sat), 32'd1);
    apply_stimulus(1'b1, MODE_CLEAR, 8'hFF, 1'b1, 1'b1);
    check_state("clear", 8'h00, 4'd0);
    check_output("clear.sat", 32'(bus.cnt_sat), 32'd0);

    // en=0 freezes everything, even with LOAD selected.
    apply_stimulus(1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0);
    check_state("pre_en", 8'h80, 4'd1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
    check_state("en_off", 8'h80, 4'd1);
    apply_stimulus(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
    check_state("en_on", 8'hFF, 4'd0);

    // PRESET after q=12, then back-to-back LOAD/SHR.
    apply_stimulus(1'b1, MODE_LOAD, 8'h24, 1'b0, 1'b0);
    apply_stimulus(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
    check_state("pre_preset", 8'h12, 4'd1);
    apply_stimulus(1'b1, MODE_PRESET, 8'h00, 1'b0, 1'b0);
    check_state("preset", 8'hA5, 4'd0);
    apply_stimulus(1'b1, MODE_LOAD, 8'h55, 1'b1, 1'b1);
    check_state("load55", 8'h55, 4'd0);
    apply_stimulus(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
    check_state("shr55", 8'h2A, 4'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
